nv_ram_rwsp_fifo_ctrl: RTL

- Controller that owns one rwsp-style RAM instance: drives its write port and its two-stage read port (ra/re, then ore).
- Presents a valid/ready push interface on the write side and a valid/ready pop interface on the read side.
- Hides the RAM's 2-cycle registered read latency and stalls the pipeline cleanly under rd_prdy backpressure.
- Sits between a producer datapath and a consumer in the NVDLA core clock domain; the paired RAM is instantiated by the parent.

---
 rtl/nv_ram_rwsp_fifo_pkg.sv | 19 +
 rtl/nv_ram_rwsp_fifo_ctrl_chk.sv | 49 ++++
 rtl/nv_ram_rwsp_fifo_rdpipe.sv | 64 ++++++
 rtl/nv_ram_rwsp_fifo_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/nv_ram_rwsp_fifo_pkg.sv
// Shared defaults and helpers for the rwsp RAM FIFO controller.
package nv_ram_rwsp_fifo_pkg;

   localparam int unsigned DEPTH_DEF = 32'd4;
   localparam int unsigned AW_DEF    = 32'd2;
   localparam int unsigned WIDTH_DEF = 32'd128;

   // Advance a ring pointer by one, wrapping from depth-1 back to 0.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
      logic [31:0] nxt_s;
      if (ptr == (depth - 32'd1)) begin
         nxt_s = 32'd0;
      end else begin
         nxt_s = ptr + 32'd1;
      end
      return nxt_s;
   endfunction

endpackage

// File: rtl/nv_ram_rwsp_fifo_ctrl_chk.sv
// Invariant checker for the FIFO controller bookkeeping and output hold.
module nv_ram_rwsp_fifo_ctrl_chk #(
   parameter int unsigned DEPTH = 32'd4,
   parameter int unsigned AW    = 32'd2,
   parameter int unsigned WIDTH = 32'd128
) (
   input logic             clk,
   input logic             rstn,
   input logic [AW:0]      cnt,
   input logic [AW:0]      avail,
   input logic             s1_vld,
   input logic             s2_vld,
   input logic             rd_pvld,
   input logic             rd_prdy,
   input logic [WIDTH-1:0] rd_pd
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic             hold_q;
   logic [WIDTH-1:0] pd_q;
   logic [AW:0]      inflight_s;

   assign inflight_s = avail + {{AW{1'b0}}, s1_vld} + {{AW{1'b0}}, s2_vld};

   // Remember whether the previous cycle stalled a valid output, and its data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hold_q <= 1'b0;
         pd_q   <= {WIDTH{1'b0}};
      end else begin
         hold_q <= rd_pvld & ~rd_prdy;
         pd_q   <= rd_pd;
      end
   end

   // Occupancy relations and stall stability, checked outside reset.
   always @(posedge clk) begin
      if (rstn) begin
         assert (cnt <= FULL_CNT);
         assert (avail <= cnt);
         assert (cnt == inflight_s);
         if (hold_q) begin
            assert (rd_pvld && (rd_pd == pd_q));
         end
      end
   end

endmodule

// File: rtl/nv_ram_rwsp_fifo_rdpipe.sv
// Tracks the two RAM read stages (address latch s1, output register s2)
// and generates the RAM re/ore strobes and the pop handshake.
module nv_ram_rwsp_fifo_rdpipe
   import nv_ram_rwsp_fifo_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic avail_nz,
   input  logic rd_prdy,
   output logic ram_re,
   output logic ram_ore,
   output logic rd_pvld,
   output logic pop,
   output logic s1_vld,
   output logic s2_vld
);

   logic s1_vld_q, s1_vld_d;
   logic s2_vld_q, s2_vld_d;
   logic ore_s, re_s, pop_s;

   // Strobe generation and next-state of both stage valids.
   always_comb begin
      ore_s    = s1_vld_q & (~s2_vld_q | rd_prdy);
      re_s     = avail_nz & (~s1_vld_q | ore_s);
      pop_s    = s2_vld_q & rd_prdy;
      s1_vld_d = s1_vld_q;
      s2_vld_d = s2_vld_q;
      if (re_s) begin
         s1_vld_d = 1'b1;
      end else if (ore_s) begin
         s1_vld_d = 1'b0;
      end else begin
         s1_vld_d = s1_vld_q;
      end
      if (ore_s) begin
         s2_vld_d = 1'b1;
      end else if (pop_s) begin
         s2_vld_d = 1'b0;
      end else begin
         s2_vld_d = s2_vld_q;
      end
   end

   // Stage valid registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
      end
   end

   // Strobes are forced low while reset is held so the RAM sees no activity.
   assign ram_re  = rstn & re_s;
   assign ram_ore = rstn & ore_s;
   assign rd_pvld = rstn & s2_vld_q;
   assign pop     = rstn & pop_s;
   assign s1_vld  = s1_vld_q;
   assign s2_vld  = s2_vld_q;

endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around one rwsp RAM with a
// two-stage registered read port.
module nv_ram_rwsp_fifo_ctrl
   import nv_ram_rwsp_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic             ram_we,
   output logic [AW-1:0]    ram_wa,
   output logic [WIDTH-1:0] ram_di,
   output logic             ram_re,
   output logic [AW-1:0]    ram_ra,
   output logic             ram_ore,
   input  logic [WIDTH-1:0] ram_dout,
   input  logic [31:0]      pwrbus_ram_pd
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   avail_q, avail_d;
   logic          pop_s, s1_vld_s, s2_vld_s, avail_nz_s;
   logic          unused_pwrbus_s;

   // Power control is routed to the RAM by the parent; nothing to do here.
   assign unused_pwrbus_s = ^pwrbus_ram_pd;

   // Full is judged on the registered count, so a pop never frees a slot
   // in the same cycle; in-flight s1/s2 slots stay reserved until popped.
   assign wr_prdy    = nvdla_core_rstn & (cnt_q != FULL_CNT);
   assign ram_we     = wr_pvld & wr_prdy;
   assign ram_wa     = wr_ptr_q;
   assign ram_di     = wr_pd;
   assign ram_ra     = rd_ptr_q;
   assign rd_pd      = ram_dout;
   assign avail_nz_s = (avail_q != {(AW+1){1'b0}});

   nv_ram_rwsp_fifo_rdpipe u_rdpipe (
      .clk      (nvdla_core_clk),
      .rstn     (nvdla_core_rstn),
      .avail_nz (avail_nz_s),
      .rd_prdy  (rd_prdy),
      .ram_re   (ram_re),
      .ram_ore  (ram_ore),
      .rd_pvld  (rd_pvld),
      .pop      (pop_s),
      .s1_vld   (s1_vld_s),
      .s2_vld   (s2_vld_s)
   );

   // Pointer advance and occupancy bookkeeping for the next edge.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (ram_we) begin
         wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (ram_re) begin
         rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      cnt_d   = cnt_q + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, pop_s};
      avail_d = avail_q + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, ram_re};
   end

   // Pointer and counter registers with synchronous active-low reset.
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         cnt_q    <= {(AW+1){1'b0}};
         avail_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         avail_q  <= avail_d;
      end
   end

   nv_ram_rwsp_fifo_ctrl_chk #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .WIDTH (WIDTH)
   ) u_chk (
      .clk     (nvdla_core_clk),
      .rstn    (nvdla_core_rstn),
      .cnt     (cnt_q),
      .avail   (avail_q),
      .s1_vld  (s1_vld_s),
      .s2_vld  (s2_vld_s),
      .rd_pvld (rd_pvld),
      .rd_prdy (rd_prdy),
      .rd_pd   (rd_pd)
   );

endmodule
